pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Parametrised successor to the fixed five-state test-harness controller.
- Sequences the PEECC data path: generator, encoder, bus, decoder, counters/comparators.
- Fills the pipeline one stage at a time, runs a programmable number of words (or runs continuously), then drains stage by stage.
- Adds stall, abort, a word count and a completion pulse.

Parameters:
- NUM_STAGES, 5, number of pipeline stage enables (≥2)
- STAGE_CYCLES, 2, dwell cycles between successive stage enable/disable steps (≥1)
- CNT_W, 16, width of the word-count input and the words_done output

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- continuous  in  1  1 = RUN until deasserted; 0 = RUN for num_words words
- num_words  in  CNT_W  word count for single-shot mode; latched on accepted start
- stall  in  1  freeze the sequencer; all enables gated low
- abort  in  1  terminate immediately
- stage_en  out  NUM_STAGES  stage enables; bit 0 = generator, bit N-1 = last stage
- trigger  out  1  one-cycle pulse when a new stage enable turns on
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- aborted  out  1  one-cycle pulse after an abort
- words_done  out  CNT_W  RUN words issued in the current/last run; saturates at all-ones

Behaviour:
- Reset (reset_n=0, async): state IDLE; dwell counter, word counter, stage_en, trigger, done, aborted all 0; words_done 0.
- States: IDLE, FILL, RUN, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 latches num_words and continuous, clears words_done, and enters FILL.
  - In the next cycle stage_en=...001 and trigger=1.
  - start=1 in any other state is ignored.
- FILL:
  - The dwell counter counts 0..STAGE_CYCLES-1 on non-stalled cycles.
  - At each wrap the next stage_en bit is set (thermometer fill from LSB) and trigger pulses.
  - When the bit that makes stage_en all-ones is set, the state moves to RUN.
  - Latency from start to stage_en[k] = 1 + k*STAGE_CYCLES cycles.
- RUN:
  - stage_en is all-ones.
  - Each non-stalled cycle is one issued word: word counter += 1 and words_done += 1 (saturating).
  - Single-shot: after num_words issued words, enter DRAIN. A latched num_words=0 means FILL goes directly to DRAIN.
  - Continuous: the continuous input is re-sampled every cycle; when it is 0, enter DRAIN.
- DRAIN:
  - On entry stage_en bit 0 clears.
  - Every STAGE_CYCLES non-stalled cycles the next-lowest set bit clears.
  - When stage_en reaches 0, enter DONE.
- DONE: done=1 for exactly one cycle with stage_en=0, then IDLE.
- stall=1 (FILL/RUN/DRAIN):
  - State, dwell counter and word counter are frozen.
  - stage_en output forced to 0; trigger suppressed. A pending trigger is issued on the first non-stalled cycle.
  - Output enables restore the cycle after stall drops.
  - Stall has no effect in IDLE or DONE.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, stage_en=0, aborted=1 for one cycle, no done.
  - words_done holds its value.
  - abort takes priority over stall, start, and the RUN/DRAIN transitions. abort in IDLE is ignored.
- start and abort in the same IDLE cycle: start wins, because abort is ignored in IDLE.
- The dwell counter is width clog2(STAGE_CYCLES)+1. With STAGE_CYCLES=1, one step happens per non-stalled cycle.

Decomposition:
- Shared package peecc_ctrl_pkg holds:
  - the state enum (IDLE, FILL, RUN, DRAIN, DONE)
  - default NUM_STAGES/STAGE_CYCLES constants
  - a clog2 helper function
- One natural sub-module, stage_timer: a dwell counter with enable/stall/clear inputs and a wrap pulse output. It is instantiated once and reused by FILL and DRAIN.

Test Plan:
- NUM_STAGES=5, STAGE_CYCLES=2, num_words=3, start at cycle 0 -> expected waveform:
  - stage_en=00001@1, 00011@3, 00111@5, 01111@7, 11111@9..11
  - trigger pulses @1,3,5,7,9
  - stage_en=11110@12, 11100@14, 11000@16, 10000@18
  - done=1 @20; busy=0 @21; words_done=3
- Same config, stall=1 for cycles 4..6 -> stage_en=0 during 4..6, 00111 appears @8 instead of @5, every later event shifted +3; words_done=3.
- continuous=1, num_words=0, continuous dropped at cycle 14 -> RUN @9..14, words_done=6, DRAIN starts @15 (11110), done @23.
- abort=1 at cycle 10 during RUN -> @11 stage_en=0, aborted=1, busy=0, done never pulses, words_done=2; a new start @12 yields 00001 @13 and words_done cleared.
- reset_n pulled low at cycle 6 mid-FILL -> all outputs 0 asynchronously; after release, start is required before any enable rises.
- single-shot num_words=0 -> FILL completes @9 with 11111, then 11110 @10; done @18; words_done=0. start pulses while busy are ignored.

Source files
------------

// File: rtl/peecc_ctrl_pkg.sv
// Shared types and constants for the PEECC pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peecc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  localparam int DEF_NUM_STAGES   = 5;
  localparam int DEF_STAGE_CYCLES = 2;
  localparam int DEF_CNT_W        = 16;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Dwell counter that pulses wrap on every STAGE_CYCLES-th enabled, non-stalled cycle.
// Latency: wrap is combinational from the count register (same cycle).
// Backpressure: stall freezes the count and suppresses wrap; clr forces the count to zero.
module stage_timer
  import peecc_ctrl_pkg::*;
#(
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic stall,
  input  logic clr,
  output logic wrap
);

  localparam int            CW   = clog2(STAGE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STAGE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign wrap = en && !stall && (cnt == LAST);

  // Count 0..STAGE_CYCLES-1 on enabled, non-stalled cycles; clear has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !stall) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Fills PEECC stage enables one at a time, runs N words (or continuously), then drains.
// Latency: start to stage_en[k] is 1 + k*STAGE_CYCLES cycles; all outputs registered.
// Backpressure: stall freezes sequencing and gates enables low; abort returns to idle next cycle.
module pipeline_sequencer
  import peecc_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [CNT_W-1:0]      num_words,
  input  logic                  stall,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      words_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t            state_q, state_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]      nw_q, nw_d;
  logic [CNT_W-1:0]      words_d;
  logic                  cont_q, cont_d;
  logic                  trig_d, done_d, aborted_d;
  logic                  gate, wrap, timer_en;

  assign timer_en = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  // Stall only matters while the pipeline is actually sequenced.
  assign gate     = stall && (timer_en || (state_q == ST_RUN));

  stage_timer #(
    .STAGE_CYCLES(STAGE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (timer_en),
    .stall  (stall),
    .clr    (!timer_en),
    .wrap   (wrap)
  );

  // Next-state and next-output decode; abort overrides every other transition.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    word_cnt_d = word_cnt_q;
    nw_d       = nw_q;
    cont_d     = cont_q;
    words_d    = words_done;
    trig_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nw_d       = num_words;
          cont_d     = continuous;
          words_d    = '0;
          word_cnt_d = '0;
          en_d       = NUM_STAGES'(1);
          trig_d     = 1'b1;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (wrap) begin
          en_d   = {en_q[NUM_STAGES-2:0], 1'b1};
          trig_d = 1'b1;
          if (en_q[NUM_STAGES-2]) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (!cont_q && (nw_q == '0)) begin
            // Zero-length single shot: pass straight through without issuing a word.
            state_d = ST_DRAIN;
            en_d    = {en_q[NUM_STAGES-1:1], 1'b0};
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (words_done != CNT_MAX) words_d = words_done + 1'b1;
            if (cont_q ? !continuous : (word_cnt_d == nw_q)) begin
              state_d = ST_DRAIN;
              en_d    = {en_q[NUM_STAGES-1:1], 1'b0};
            end
          end
        end
      end
      ST_DRAIN: begin
        if (wrap) begin
          en_d = en_q & (en_q - 1'b1);
          if (en_d == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The word issued in the abort cycle still counts; only the sequencing stops.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      en_d      = '0;
      trig_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // State and run-context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      word_cnt_q <= '0;
      nw_q       <= '0;
      cont_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      word_cnt_q <= word_cnt_d;
      nw_q       <= nw_d;
      cont_q     <= cont_d;
    end
  end

  // Registered outputs; enables are gated low on stalled cycles. Steps only
  // advance on non-stalled cycles, so a trigger is never due while gated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_en   <= '0;
      trigger    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
    end else begin
      stage_en   <= gate ? '0 : en_d;
      trigger    <= trig_d && !gate;
      busy       <= (state_d != ST_IDLE);
      done       <= done_d;
      aborted    <= aborted_d;
      words_done <= words_d;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench: two sequencer configurations driven in lockstep against a level-based model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: stall and abort exercised by directed and random stimulus.
module tb_pipeline_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  typedef struct {
    int          phase;
    int          level;   // number of stages currently enabled
    int          ticks;   // non-stalled cycles since the last stage step
    int          words;   // words issued this run (unbounded)
    int          nwl;
    bit          contl;
    logic [31:0] en;
    bit          trig;
    bit          busy;
    bit          done;
    bit          abt;
    int          wd;
  } model_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        continuous;
  logic [15:0] num_words;
  logic        stall;
  logic        abort;

  logic [4:0]  stage_en1;
  logic        trigger1, busy1, done1, aborted1;
  logic [15:0] words_done1;
  logic [1:0]  stage_en2;
  logic        trigger2, busy2, done2, aborted2;
  logic [2:0]  words_done2;

  logic [24:0] obs1;
  logic [8:0]  obs2;
  assign obs1 = {stage_en1, trigger1, busy1, done1, aborted1, words_done1};
  assign obs2 = {stage_en2, trigger2, busy2, done2, aborted2, words_done2};

  int     checks;
  int     errors;
  model_t m1, m2;

  pipeline_sequencer #(.NUM_STAGES(5), .STAGE_CYCLES(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .num_words(num_words), .stall(stall), .abort(abort),
    .stage_en(stage_en1), .trigger(trigger1), .busy(busy1), .done(done1),
    .aborted(aborted1), .words_done(words_done1)
  );

  pipeline_sequencer #(.NUM_STAGES(2), .STAGE_CYCLES(1), .CNT_W(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .num_words(num_words[2:0]), .stall(stall), .abort(abort),
    .stage_en(stage_en2), .trigger(trigger2), .busy(busy2), .done(done2),
    .aborted(aborted2), .words_done(words_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r = '{default: 0};
    return r;
  endfunction

  // One clock of the reference behaviour, from the sampled inputs.
  function automatic model_t step(model_t m, bit st, bit ct, int nw, bit sl, bit ab,
                                  int n, int sc, int cw);
    model_t      r;
    bit          gate;
    logic [31:0] ones;
    r      = m;
    gate   = sl && (m.phase == P_FILL || m.phase == P_RUN || m.phase == P_DRAIN);
    r.trig = 0;
    r.done = 0;
    r.abt  = 0;
    if (m.phase != P_IDLE && ab) begin
      if (m.phase == P_RUN && !sl && (m.contl || m.nwl != 0)) r.words++;
      r.phase = P_IDLE;
      r.level = 0;
      r.abt   = 1;
    end else begin
      case (m.phase)
        P_IDLE: if (st) begin
          r.nwl = nw; r.contl = ct; r.words = 0;
          r.phase = P_FILL; r.level = 1; r.ticks = 0; r.trig = 1;
        end
        P_FILL: if (!sl) begin
          r.ticks++;
          if (r.ticks == sc) begin
            r.ticks = 0; r.level++; r.trig = 1;
            if (r.level == n) r.phase = P_RUN;
          end
        end
        P_RUN: if (!sl) begin
          if (!m.contl && m.nwl == 0) begin
            r.phase = P_DRAIN; r.level = n - 1; r.ticks = 0;
          end else begin
            r.words++;
            if (m.contl ? !ct : (r.words == m.nwl)) begin
              r.phase = P_DRAIN; r.level = n - 1; r.ticks = 0;
            end
          end
        end
        P_DRAIN: if (!sl) begin
          r.ticks++;
          if (r.ticks == sc) begin
            r.ticks = 0; r.level--;
            if (r.level == 0) begin r.phase = P_DONE; r.done = 1; end
          end
        end
        default: r.phase = P_IDLE;
      endcase
    end
    r.busy = (r.phase != P_IDLE);
    r.wd   = (r.words > (1 << cw) - 1) ? (1 << cw) - 1 : r.words;
    ones   = (32'd1 << r.level) - 32'd1;
    if (gate) r.en = '0;
    else if (r.phase == P_FILL || r.phase == P_RUN) r.en = ones;
    else if (r.phase == P_DRAIN) r.en = ones << (n - r.level);
    else r.en = '0;
    return r;
  endfunction

  function automatic logic [24:0] exp1_of(model_t m);
    return {m.en[4:0], m.trig, m.busy, m.done, m.abt, 16'(m.wd)};
  endfunction

  function automatic logic [8:0] exp2_of(model_t m);
    return {m.en[1:0], m.trig, m.busy, m.done, m.abt, 3'(m.wd)};
  endfunction

  task automatic tick();
    m1 = step(m1, start, continuous, int'(num_words), stall, abort, 5, 2, 16);
    m2 = step(m2, start, continuous, int'(num_words[2:0]), stall, abort, 2, 1, 3);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; continuous = 1'b0; num_words = 16'd3;
    stall = 1'b0; abort = 1'b0;
    m1 = model_reset(); m2 = model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (obs1 !== 25'd0) begin errors++; $display("FAIL reset dut1: got %h want 0", obs1); end
    checks++; if (obs2 !== 9'd0) begin errors++; $display("FAIL reset dut2: got %h want 0", obs2); end
    start = 1'b0; reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL reset_idle dut1 c%0d: got %h want %h", c, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL reset_idle dut2 c%0d: got %h want %h", c, obs2, exp2_of(m2)); end
    end
  endtask

  task automatic test_single_shot();
    logic [4:0] tbl [22] = '{0, 1,1,3,3,7,7,15,15,31,31,31,30,30,28,28,24,24,16,16,0,0};
    int oc;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0); num_words = 16'd3; continuous = 1'b0; stall = 1'b0; abort = 1'b0;
      tick();
      oc = c + 1;
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL single dut1 @%0d: got %h want %h", oc, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL single dut2 @%0d: got %h want %h", oc, obs2, exp2_of(m2)); end
      checks++; if (stage_en1 !== tbl[oc]) begin errors++; $display("FAIL single_en @%0d: got %b want %b", oc, stage_en1, tbl[oc]); end
      checks++; if (trigger1 !== (oc inside {1, 3, 5, 7, 9})) begin errors++; $display("FAIL single_trig @%0d: got %b", oc, trigger1); end
      checks++; if (done1 !== (oc == 20)) begin errors++; $display("FAIL single_done @%0d: got %b", oc, done1); end
      checks++; if (busy1 !== (oc <= 20)) begin errors++; $display("FAIL single_busy @%0d: got %b", oc, busy1); end
    end
    checks++; if (words_done1 !== 16'd3) begin errors++; $display("FAIL single_words: got %0d want 3", words_done1); end
  endtask

  task automatic test_stall();
    logic [4:0] tbl [25] = '{0, 1,1,3,0,0,0,3,7,7,15,15,31,31,31,30,30,28,28,24,24,16,16,0,0};
    int oc;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0); num_words = 16'd3; continuous = 1'b0; abort = 1'b0;
      stall = (c >= 3 && c <= 5);
      tick();
      oc = c + 1;
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL stall dut1 @%0d: got %h want %h", oc, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL stall dut2 @%0d: got %h want %h", oc, obs2, exp2_of(m2)); end
      checks++; if (stage_en1 !== tbl[oc]) begin errors++; $display("FAIL stall_en @%0d: got %b want %b", oc, stage_en1, tbl[oc]); end
      checks++; if (done1 !== (oc == 23)) begin errors++; $display("FAIL stall_done @%0d: got %b", oc, done1); end
    end
    stall = 1'b0;
    checks++; if (words_done1 !== 16'd3) begin errors++; $display("FAIL stall_words: got %0d want 3", words_done1); end
  endtask

  task automatic test_continuous();
    int oc;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0); num_words = 16'd0; stall = 1'b0; abort = 1'b0;
      continuous = (c < 14);
      tick();
      oc = c + 1;
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL cont dut1 @%0d: got %h want %h", oc, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL cont dut2 @%0d: got %h want %h", oc, obs2, exp2_of(m2)); end
      if (oc >= 9 && oc <= 14) begin
        checks++; if (stage_en1 !== 5'b11111) begin errors++; $display("FAIL cont_run @%0d: got %b want 11111", oc, stage_en1); end
      end
      checks++; if (done1 !== (oc == 23)) begin errors++; $display("FAIL cont_done @%0d: got %b", oc, done1); end
    end
    checks++; if (words_done1 !== 16'd6) begin errors++; $display("FAIL cont_words: got %0d want 6", words_done1); end
    checks++; if (words_done2 !== 3'd7) begin errors++; $display("FAIL cont_saturate: got %0d want 7", words_done2); end
  endtask

  task automatic test_abort();
    int oc;
    for (int c = 0; c <= 34; c++) begin
      start = (c == 0 || c == 12); num_words = 16'd3; continuous = 1'b0; stall = 1'b0;
      abort = (c == 10);
      tick();
      oc = c + 1;
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL abort dut1 @%0d: got %h want %h", oc, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL abort dut2 @%0d: got %h want %h", oc, obs2, exp2_of(m2)); end
      if (oc <= 12) begin
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL abort_nodone @%0d: got %b want 0", oc, done1); end
      end
      if (oc == 11) begin
        checks++; if ({stage_en1, aborted1, busy1} !== 7'b0000010) begin errors++; $display("FAIL abort_pulse: got en=%b ab=%b busy=%b", stage_en1, aborted1, busy1); end
        checks++; if (words_done1 !== 16'd2) begin errors++; $display("FAIL abort_words: got %0d want 2", words_done1); end
      end
      if (oc == 13) begin
        checks++; if ({stage_en1, trigger1, words_done1} !== {5'b00001, 1'b1, 16'd0}) begin errors++; $display("FAIL abort_restart: got en=%b trig=%b wd=%0d", stage_en1, trigger1, words_done1); end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 5; c++) begin
      start = (c == 0); num_words = 16'd3; continuous = 1'b0; stall = 1'b0; abort = 1'b0;
      tick();
    end
    checks++; if (stage_en1 !== 5'b00111) begin errors++; $display("FAIL arst_pre: got %b want 00111", stage_en1); end
    #2 reset_n = 1'b0;
    #1;
    m1 = model_reset(); m2 = model_reset();
    checks++; if (obs1 !== 25'd0) begin errors++; $display("FAIL arst dut1: got %h want 0", obs1); end
    checks++; if (obs2 !== 9'd0) begin errors++; $display("FAIL arst dut2: got %h want 0", obs2); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      start = 1'b0;
      tick();
      checks++; if ({stage_en1, busy1} !== 6'd0) begin errors++; $display("FAIL arst_idle c%0d: got en=%b busy=%b", c, stage_en1, busy1); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL arst dut2 c%0d: got %h want %h", c, obs2, exp2_of(m2)); end
    end
  endtask

  task automatic test_zero_words();
    logic [4:0] tbl [21] = '{0, 1,1,3,3,7,7,15,15,31,30,30,28,28,24,24,16,16,0,0,0};
    int oc;
    for (int c = 0; c <= 19; c++) begin
      start = (c == 0 || c == 4 || c == 8 || c == 12 || c == 16);
      num_words = (c == 0) ? 16'd0 : 16'd5;
      continuous = 1'b0; stall = 1'b0; abort = 1'b0;
      tick();
      oc = c + 1;
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL zero dut1 @%0d: got %h want %h", oc, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL zero dut2 @%0d: got %h want %h", oc, obs2, exp2_of(m2)); end
      checks++; if (stage_en1 !== tbl[oc]) begin errors++; $display("FAIL zero_en @%0d: got %b want %b", oc, stage_en1, tbl[oc]); end
      checks++; if ({done1, busy1, words_done1} !== {oc == 18, oc <= 18, 16'd0}) begin errors++; $display("FAIL zero_ctl @%0d: got done=%b busy=%b wd=%0d", oc, done1, busy1, words_done1); end
    end
  endtask

  task automatic test_random();
    bit cont_bit;
    cont_bit = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) cont_bit = ~cont_bit;
      start      = ($urandom_range(0, 7) == 0);
      continuous = cont_bit;
      num_words  = 16'($urandom_range(0, 6));
      stall      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      tick();
      checks++; if (obs1 !== exp1_of(m1)) begin errors++; $display("FAIL random dut1 c%0d: got %h want %h", c, obs1, exp1_of(m1)); end
      checks++; if (obs2 !== exp2_of(m2)) begin errors++; $display("FAIL random dut2 c%0d: got %h want %h", c, obs2, exp2_of(m2)); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_shot();
    test_stall();
    test_continuous();
    test_abort();
    test_async_reset();
    test_zero_words();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
